// File: rtl/riscv_regfile_sb_if.sv
// Bundles the decode-side read ports and the issue/writeback/flush controls of riscv_regfile_sb.
// The master drives addresses and pipeline events; the slave is the register file.
interface riscv_regfile_sb_if #(
  parameter int READ_PORTS = 2,
  parameter int XLEN       = 32,
  parameter int NREGS      = 32
);
  localparam int AW = $clog2(NREGS);

  logic [READ_PORTS*AW-1:0]   rs_addr;
  logic [READ_PORTS*XLEN-1:0] rs_data;
  logic [READ_PORTS-1:0]      rs_busy;
  logic                       issue_vld;
  logic [AW-1:0]              issue_rd;
  logic                       wb_vld;
  logic [AW-1:0]              wb_rd;
  logic [XLEN-1:0]            wb_data;
  logic                       flush;
  logic [NREGS-1:0]           busy_vec;

  modport master (
    output rs_addr, issue_vld, issue_rd, wb_vld, wb_rd, wb_data, flush,
    input  rs_data, rs_busy, busy_vec
  );

  modport slave (
    input  rs_addr, issue_vld, issue_rd, wb_vld, wb_rd, wb_data, flush,
    output rs_data, rs_busy, busy_vec
  );
endinterface

// File: rtl/riscv_regfile_sb.sv
// Integer register file with READ_PORTS bypassed read ports and a busy scoreboard
// that tracks in-flight producers so issue logic can stall on RAW hazards.
module riscv_regfile_sb #(
  parameter int READ_PORTS = 2,
  parameter int XLEN       = 32,
  parameter int NREGS      = 32
) (
  input logic              clk,
  input logic              rst,
  riscv_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_vld && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Flush beats issue beats writeback; a new producer supersedes a same-cycle completion.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.wb_vld) busy_d[bus.wb_rd] = 1'b0;
      if (bus.issue_vld && bus.issue_rd != '0) busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.busy_vec = busy_q;

  // Reset forces read outputs low even if a writeback is presented during reset.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [AW-1:0]   addr;
    logic            wb_hit;
    logic [XLEN-1:0] data;

    assign addr   = bus.rs_addr[p*AW +: AW];
    assign wb_hit = bus.wb_vld && (bus.wb_rd == addr);

    always_comb begin
      data = '0;
      if (!rst && addr != '0) begin
        if (wb_hit) data = bus.wb_data;
        else        data = regs[addr];
      end
    end

    assign bus.rs_data[p*XLEN +: XLEN] = data;
    assign bus.rs_busy[p] = !rst && busy_q[addr] && !wb_hit;
  end
endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Randomised self-checking bench for riscv_regfile_sb against an array-based reference model,
// plus directed scenarios and an RV32E three-port instance.
module tb_riscv_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  riscv_regfile_sb_if #(.READ_PORTS(2), .XLEN(32), .NREGS(32)) bus ();
  riscv_regfile_sb_if #(.READ_PORTS(3), .XLEN(32), .NREGS(16)) bus_e ();

  riscv_regfile_sb #(.READ_PORTS(2), .XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  riscv_regfile_sb #(.READ_PORTS(3), .XLEN(32), .NREGS(16)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ir, input logic wv,
                               input logic [4:0] wr, input logic [31:0] wd, input logic fl,
                               input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    bus.issue_vld = iv;
    bus.issue_rd  = ir;
    bus.wb_vld    = wv;
    bus.wb_rd     = wr;
    bus.wb_data   = wd;
    bus.flush     = fl;
    bus.rs_addr   = {a1, a0};
    #1;
  endtask

  task automatic check_model();
    logic [4:0]  a;
    logic        hit;
    logic [31:0] exp_d;
    logic        exp_b;
    logic [31:0] exp_v;
    for (int p = 0; p < 2; p++) begin
      a     = bus.rs_addr[p*5 +: 5];
      hit   = bus.wb_vld && bus.wb_rd == a;
      exp_d = (a == 0) ? 32'h0 : (hit ? bus.wb_data : m_regs[a]);
      exp_b = m_busy[a] && !hit;
      checkOutput($sformatf("rs_data%0d_x%0d", p, a), 64'(bus.rs_data[p*32 +: 32]), 64'(exp_d));
      checkOutput($sformatf("rs_busy%0d_x%0d", p, a), 64'(bus.rs_busy[p]), 64'(exp_b));
    end
    exp_v = '0;
    for (int i = 1; i < 32; i++) exp_v[i] = m_busy[i];
    checkOutput("busy_vec", 64'(bus.busy_vec), 64'(exp_v));
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic clock_edge();
    @(posedge clk);
    if (bus.wb_vld && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (bus.wb_vld) m_busy[bus.wb_rd] = 1'b0;
      if (bus.issue_vld && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
  endtask

  task automatic step(input logic iv, input logic [4:0] ir, input logic wv, input logic [4:0] wr,
                      input logic [31:0] wd, input logic fl, input logic [4:0] a0, input logic [4:0] a1);
    applyStimulus(iv, ir, wv, wr, wd, fl, a0, a1);
    check_model();
    clock_edge();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = {5'(a), 5'(a)};
      #1;
      checkOutput($sformatf("%s_data0_x%0d", tag, a), 64'(bus.rs_data[31:0]), 64'h0);
      checkOutput($sformatf("%s_data1_x%0d", tag, a), 64'(bus.rs_data[63:32]), 64'h0);
      checkOutput($sformatf("%s_busy_x%0d", tag, a), 64'(bus.rs_busy), 64'h0);
    end
    checkOutput({tag, "_busy_vec"}, 64'(bus.busy_vec), 64'h0);
    checkOutput({tag, "_e_busy_vec"}, 64'(bus_e.busy_vec), 64'h0);
  endtask

  initial begin
    bus.issue_vld = 0; bus.issue_rd = 0; bus.wb_vld = 0; bus.wb_rd = 0;
    bus.wb_data = 0; bus.flush = 0; bus.rs_addr = 0;
    bus_e.issue_vld = 0; bus_e.issue_rd = 0; bus_e.wb_vld = 0; bus_e.wb_rd = 0;
    bus_e.wb_data = 0; bus_e.flush = 0; bus_e.rs_addr = 0;
    model_reset();

    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write then read: same-cycle bypass, then storage on the other port.
    applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
    checkOutput("bypass_x5", 64'(bus.rs_data[31:0]), 64'hDEADBEEF);
    check_model();
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
    checkOutput("stored_x5", 64'(bus.rs_data[63:32]), 64'hDEADBEEF);
    check_model();
    clock_edge();
    step(0, 0, 1, 0, 32'h1234, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_data", 64'(bus.rs_data[31:0]), 64'h0);
    checkOutput("x0_busy", 64'(bus.busy_vec[0]), 64'h0);
    clock_edge();

    // Scoreboard lifetime of x7.
    applyStimulus(1, 7, 0, 0, 0, 0, 7, 7);
    checkOutput("sb_issue_cycle", 64'(bus.rs_busy[0]), 64'h0);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("sb_n1", 64'(bus.rs_busy[0]), 64'h1);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("sb_n2", 64'(bus.rs_busy[1]), 64'h1);
    clock_edge();
    applyStimulus(0, 0, 1, 7, 32'h55, 0, 7, 0);
    checkOutput("sb_wb_busy", 64'(bus.rs_busy[0]), 64'h0);
    checkOutput("sb_wb_data", 64'(bus.rs_data[31:0]), 64'h55);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
    checkOutput("sb_n4", 64'(bus.busy_vec[7]), 64'h0);
    check_model();
    clock_edge();

    // Issue and writeback of x3 together: new producer stays busy, data still lands.
    step(1, 3, 1, 3, 32'hCAFE0003, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
    checkOutput("iss_wb_busy", 64'(bus.busy_vec[3]), 64'h1);
    checkOutput("iss_wb_data", 64'(bus.rs_data[31:0]), 64'hCAFE0003);
    clock_edge();

    // Flush drops everything including a same-cycle issue.
    step(1, 9, 0, 0, 0, 0, 9, 3);
    step(1, 3, 0, 0, 0, 1, 3, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 9);
    checkOutput("flush_busy_vec", 64'(bus.busy_vec), 64'h0);
    check_model();
    clock_edge();

    // RV32E three-port instance.
    @(negedge clk);
    bus_e.wb_vld = 1; bus_e.wb_rd = 4'd15; bus_e.wb_data = 32'hA5A5A5A5;
    bus_e.issue_vld = 1; bus_e.issue_rd = 4'd15;
    @(negedge clk);
    bus_e.wb_vld = 0; bus_e.issue_vld = 0;
    bus_e.rs_addr = {4'd15, 4'd15, 4'd15};
    #1;
    for (int p = 0; p < 3; p++) begin
      checkOutput($sformatf("e_port%0d_x15", p), 64'(bus_e.rs_data[p*32 +: 32]), 64'hA5A5A5A5);
      checkOutput($sformatf("e_busy%0d_x15", p), 64'(bus_e.rs_busy[p]), 64'h1);
    end
    checkOutput("e_busy_vec", 64'(bus_e.busy_vec), 64'h8000);

    // Random traffic with a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom,
           1'($urandom_range(0, 15) == 0),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset between edges clears state immediately.
    @(negedge clk);
    bus.issue_vld = 0; bus.wb_vld = 0; bus.flush = 0;
    #2;
    rst = 1'b1;
    model_reset();
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 0,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
